// File: rtl/bcd_seg_scan.sv
// Time-multiplexed 7-segment scanner for a packed BCD word, double-buffered at frame start.
// Optional LEADING_ZERO_BLANK_EN suppresses digits above the highest nonzero digit.
module bcd_seg_scan #(
  parameter int NUM_DIGITS   = 3,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    bcd_valid,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start,
  output logic                    upd_pending
);

  localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW   = 4 * NUM_DIGITS;

  typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       active_q, active_d;
  logic [BW-1:0]       pending_q, pending_d;
  logic                upd_q, upd_d;
  logic [6:0]          seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                fs_q, fs_d;
  logic                boundary_s;
  logic [3:0]          digit_s;
  logic [IW-1:0]       hi_s;
  logic                show_en_s;

  function automatic logic [6:0] enc(input logic [3:0] v);
    case (v)
      4'd0:    enc = 7'h3F;
      4'd1:    enc = 7'h06;
      4'd2:    enc = 7'h5B;
      4'd3:    enc = 7'h4F;
      4'd4:    enc = 7'h66;
      4'd5:    enc = 7'h6D;
      4'd6:    enc = 7'h7D;
      4'd7:    enc = 7'h07;
      4'd8:    enc = 7'h7F;
      4'd9:    enc = 7'h6F;
      default: enc = 7'h40;
    endcase
  endfunction

  // Scan FSM: SHOW/BLANK timing, digit index advance, shared cycle counter.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CW'(1);
    case (state_q)
      ST_SHOW: begin
        if (cnt_q == CW'(REFRESH_DIV - 1)) begin
          state_d = ST_BLANK;
          cnt_d   = CW'(0);
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      ST_BLANK: begin
        if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
          state_d = ST_SHOW;
          cnt_d   = CW'(0);
          idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? IW'(0) : idx_q + IW'(1);
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = CW'(0);
      end
    endcase
  end

  // Double buffer: commit only on the edge entering SHOW of digit 0; a load on that edge wins.
  always_comb begin
    boundary_s = (state_q == ST_BLANK) && (state_d == ST_SHOW) && (idx_d == IW'(0));
    active_d   = active_q;
    pending_d  = pending_q;
    upd_d      = upd_q;
    if (boundary_s) begin
      if (bcd_valid) begin
        active_d = bcd_in;
      end else if (upd_q) begin
        active_d = pending_q;
      end else begin
        active_d = active_q;
      end
      upd_d = 1'b0;
    end else if (bcd_valid) begin
      pending_d = bcd_in;
      upd_d     = 1'b1;
    end else begin
      upd_d     = upd_q;
    end
  end

  // Output decode from next state so registered outputs line up with the FSM state.
  always_comb begin
    digit_s = 4'h0;
    hi_s    = IW'(0);
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (IW'(d) == idx_d) begin
        digit_s = active_d[4*d +: 4];
      end else begin
        digit_s = digit_s;
      end
      if (active_d[4*d +: 4] != 4'h0) begin
        hi_s = IW'(d);
      end else begin
        hi_s = hi_s;
      end
    end
`ifdef LEADING_ZERO_BLANK_EN
    show_en_s = (idx_d <= hi_s);
`else
    show_en_s = 1'b1;
`endif
    if ((state_d == ST_SHOW) && show_en_s) begin
      an_d  = NUM_DIGITS'(1) << idx_d;
      seg_d = enc(digit_s);
    end else begin
      an_d  = '0;
      seg_d = 7'h00;
    end
    fs_d = boundary_s;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_BLANK;
      idx_q     <= IW'(NUM_DIGITS - 1);
      cnt_q     <= CW'(0);
      active_q  <= '0;
      pending_q <= '0;
      upd_q     <= 1'b0;
      seg_q     <= 7'h00;
      an_q      <= '0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      upd_q     <= upd_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      fs_q      <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_start = fs_q;
  assign upd_pending = upd_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed bench for bcd_seg_scan with NUM_DIGITS=3, REFRESH_DIV=4, BLANK_CYCLES=1 (15-cycle frame).
module tb_bcd_seg_scan;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] bcd_in;
  logic        bcd_valid;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic        frame_start;
  logic        upd_pending;

  int n_chk  = 0;
  int n_fail = 0;

  logic [6:0] exp_code [0:2];
  logic       exp_on   [0:2];

  bcd_seg_scan #(.NUM_DIGITS(3), .REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
    .seg(seg), .an(an), .frame_start(frame_start), .upd_pending(upd_pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [11:0] v);
    bcd_in    = v;
    bcd_valid = 1'b1;
    step();
    bcd_valid = 1'b0;
  endtask

  task automatic wait_fs(input string name);
    int n = 0;
    step();
    while (frame_start !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    n_chk++;
    if (frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_wait_fs: frame_start=%b after %0d cycles, required 1", name, frame_start, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bcd_valid = 1'b0; bcd_in = 12'h000;
    repeat (3) step();
    n_chk++;
    if (an !== 3'b000 || seg !== 7'h00 || frame_start !== 1'b0 || upd_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: an=%b seg=%h fs=%b upd=%b, required 000/00/0/0", an, seg, frame_start, upd_pending);
    end
    rst = 1'b0;
    n_chk++;
    if (an !== 3'b000 || seg !== 7'h00 || frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_blank: an=%b seg=%h fs=%b, required 000/00/0", an, seg, frame_start);
    end
    step();
    exp_code = '{7'h3F, 7'h3F, 7'h3F};
    exp_on   = '{1'b1, !LZB, !LZB};
    for (int c = 0; c < 15; c++) begin
      logic [2:0] e_an; logic [6:0] e_seg;
      e_an  = ((c % 5) < 4 && exp_on[c/5]) ? (3'b001 << (c/5)) : 3'b000;
      e_seg = ((c % 5) < 4 && exp_on[c/5]) ? exp_code[c/5] : 7'h00;
      n_chk++;
      if (an !== e_an || seg !== e_seg || frame_start !== (c == 0)) begin
        n_fail++;
        $display("FAIL reset_frame c=%0d: an=%b seg=%h fs=%b, required %b/%h/%b", c, an, seg, frame_start, e_an, e_seg, c == 0);
      end
      step();
    end
    n_chk++;
    if (frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_length: fs=%b at cycle 15, required 1", frame_start);
    end
  endtask

  task automatic test_pending_load();
    step(); step();
    load(12'h255);
    n_chk++;
    if (upd_pending !== 1'b1 || an !== 3'b001 || seg !== 7'h3F) begin
      n_fail++;
      $display("FAIL pending_set: upd=%b an=%b seg=%h, required 1/001/3F", upd_pending, an, seg);
    end
    wait_fs("pending");
    n_chk++;
    if (upd_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL pending_commit: upd=%b, required 0", upd_pending);
    end
    exp_code = '{7'h6D, 7'h6D, 7'h5B};
    exp_on   = '{1'b1, 1'b1, 1'b1};
    for (int c = 0; c < 15; c++) begin
      logic [2:0] e_an; logic [6:0] e_seg;
      e_an  = ((c % 5) < 4 && exp_on[c/5]) ? (3'b001 << (c/5)) : 3'b000;
      e_seg = ((c % 5) < 4 && exp_on[c/5]) ? exp_code[c/5] : 7'h00;
      n_chk++;
      if (an !== e_an || seg !== e_seg || frame_start !== (c == 0)) begin
        n_fail++;
        $display("FAIL pending_frame c=%0d: an=%b seg=%h fs=%b, required %b/%h/%b", c, an, seg, frame_start, e_an, e_seg, c == 0);
      end
      step();
    end
  endtask

  task automatic test_last_wins();
    load(12'h123);
    load(12'h089);
    n_chk++;
    if (upd_pending !== 1'b1 || seg !== 7'h6D) begin
      n_fail++;
      $display("FAIL last_wins_hold: upd=%b seg=%h, required 1/6D", upd_pending, seg);
    end
    wait_fs("last_wins");
    exp_code = '{7'h6F, 7'h7F, 7'h3F};
    exp_on   = '{1'b1, 1'b1, !LZB};
    for (int c = 0; c < 15; c++) begin
      logic [2:0] e_an; logic [6:0] e_seg;
      e_an  = ((c % 5) < 4 && exp_on[c/5]) ? (3'b001 << (c/5)) : 3'b000;
      e_seg = ((c % 5) < 4 && exp_on[c/5]) ? exp_code[c/5] : 7'h00;
      n_chk++;
      if (an !== e_an || seg !== e_seg || frame_start !== (c == 0)) begin
        n_fail++;
        $display("FAIL last_wins_frame c=%0d: an=%b seg=%h fs=%b, required %b/%h/%b", c, an, seg, frame_start, e_an, e_seg, c == 0);
      end
      step();
    end
  endtask

  task automatic test_boundary_load();
    repeat (5) step();
    load(12'h111);
    n_chk++;
    if (upd_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL boundary_pre_pending: upd=%b, required 1", upd_pending);
    end
    repeat (8) step();
    load(12'h007);
    n_chk++;
    if (frame_start !== 1'b1 || upd_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL boundary_load: fs=%b upd=%b, required 1/0", frame_start, upd_pending);
    end
    exp_code = '{7'h07, 7'h3F, 7'h3F};
    exp_on   = '{1'b1, !LZB, !LZB};
    for (int c = 0; c < 15; c++) begin
      logic [2:0] e_an; logic [6:0] e_seg;
      e_an  = ((c % 5) < 4 && exp_on[c/5]) ? (3'b001 << (c/5)) : 3'b000;
      e_seg = ((c % 5) < 4 && exp_on[c/5]) ? exp_code[c/5] : 7'h00;
      n_chk++;
      if (an !== e_an || seg !== e_seg || frame_start !== (c == 0) || upd_pending !== 1'b0) begin
        n_fail++;
        $display("FAIL boundary_frame c=%0d: an=%b seg=%h fs=%b upd=%b, required %b/%h/%b/0", c, an, seg, frame_start, upd_pending, e_an, e_seg, c == 0);
      end
      step();
    end
  endtask

  task automatic test_invalid_codes();
    load(12'hA0F);
    wait_fs("invalid");
    exp_code = '{7'h40, 7'h3F, 7'h40};
    exp_on   = '{1'b1, 1'b1, 1'b1};
    for (int c = 0; c < 15; c++) begin
      logic [2:0] e_an; logic [6:0] e_seg;
      e_an  = ((c % 5) < 4 && exp_on[c/5]) ? (3'b001 << (c/5)) : 3'b000;
      e_seg = ((c % 5) < 4 && exp_on[c/5]) ? exp_code[c/5] : 7'h00;
      n_chk++;
      if (an !== e_an || seg !== e_seg || frame_start !== (c == 0)) begin
        n_fail++;
        $display("FAIL invalid_frame c=%0d: an=%b seg=%h fs=%b, required %b/%h/%b", c, an, seg, frame_start, e_an, e_seg, c == 0);
      end
      step();
    end
  endtask

  task automatic test_leading_zero();
    logic [11:0] vals [0:2];
    vals = '{12'h005, 12'h050, 12'h000};
    for (int v = 0; v < 3; v++) begin
      load(vals[v]);
      wait_fs("leading_zero");
      case (v)
        0: begin exp_code = '{7'h6D, 7'h3F, 7'h3F}; exp_on = '{1'b1, !LZB, !LZB}; end
        1: begin exp_code = '{7'h3F, 7'h6D, 7'h3F}; exp_on = '{1'b1, 1'b1, !LZB}; end
        default: begin exp_code = '{7'h3F, 7'h3F, 7'h3F}; exp_on = '{1'b1, !LZB, !LZB}; end
      endcase
      for (int c = 0; c < 15; c++) begin
        logic [2:0] e_an; logic [6:0] e_seg;
        e_an  = ((c % 5) < 4 && exp_on[c/5]) ? (3'b001 << (c/5)) : 3'b000;
        e_seg = ((c % 5) < 4 && exp_on[c/5]) ? exp_code[c/5] : 7'h00;
        n_chk++;
        if (an !== e_an || seg !== e_seg || frame_start !== (c == 0)) begin
          n_fail++;
          $display("FAIL leading_zero v=%h c=%0d: an=%b seg=%h fs=%b, required %b/%h/%b", vals[v], c, an, seg, frame_start, e_an, e_seg, c == 0);
        end
        step();
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    load(12'h456);
    wait_fs("midrst_commit");
    repeat (5) step();
    load(12'h789);
    n_chk++;
    if (upd_pending !== 1'b1 || an !== 3'b010 || seg !== 7'h6D) begin
      n_fail++;
      $display("FAIL midrst_pre: upd=%b an=%b seg=%h, required 1/010/6D", upd_pending, an, seg);
    end
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (an !== 3'b000 || seg !== 7'h00 || frame_start !== 1'b0 || upd_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async: an=%b seg=%h fs=%b upd=%b, required 000/00/0/0", an, seg, frame_start, upd_pending);
    end
    step(); step();
    rst = 1'b0;
    step();
    exp_code = '{7'h3F, 7'h3F, 7'h3F};
    exp_on   = '{1'b1, !LZB, !LZB};
    for (int c = 0; c < 15; c++) begin
      logic [2:0] e_an; logic [6:0] e_seg;
      e_an  = ((c % 5) < 4 && exp_on[c/5]) ? (3'b001 << (c/5)) : 3'b000;
      e_seg = ((c % 5) < 4 && exp_on[c/5]) ? exp_code[c/5] : 7'h00;
      n_chk++;
      if (an !== e_an || seg !== e_seg || frame_start !== (c == 0) || upd_pending !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_frame c=%0d: an=%b seg=%h fs=%b upd=%b, required %b/%h/%b/0", c, an, seg, frame_start, upd_pending, e_an, e_seg, c == 0);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_pending_load();
    test_last_wins();
    test_boundary_load();
    test_invalid_codes();
    test_leading_zero();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
